// File: rtl/regfile16x32_sb.sv
// 16-entry register file with one-hot write-back port, two registered read ports
// and a busy-bit scoreboard that stalls reads of registers still owned by multicycle ops.
module regfile16x32_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [15:0]       wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              stall,
    input  logic              sb_set,
    input  logic [3:0]        sb_addr,
    output logic [15:0]       busy,
    output logic              sel_err
);

    localparam int unsigned NREG = 16;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              sel_err_q, sel_err_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

    logic              sel_onehot;
    logic              wr_legal;
    logic [NREG-1:0]   wr_hit;
    logic [NREG-1:0]   sb_vec;
    logic              pend_a, pend_b;
    logic              accept;
    logic [DATA_W-1:0] opnd_a, opnd_b;

    // Write legality and per-register write hits (r0 masked when hardwired to zero)
    always_comb begin
        sel_onehot = (wr_sel != 16'd0) && ((wr_sel & (wr_sel - 16'd1)) == 16'd0);
        wr_legal   = wr_en && sel_onehot;
        wr_hit     = wr_legal ? wr_sel : '0;
        sb_vec     = sb_set ? (16'd1 << sb_addr) : 16'd0;
        if (R0_ZERO) begin
            wr_hit[0] = 1'b0;
            sb_vec[0] = 1'b0;
        end
    end

    // A write landing this cycle releases the dependency on its target
    always_comb begin
        pend_a = busy_q[rd_addr_a] && !wr_hit[rd_addr_a];
        pend_b = busy_q[rd_addr_b] && !wr_hit[rd_addr_b];
        stall  = rd_req && (pend_a || pend_b);
        accept = rd_req && !stall;
    end

    // Operand select with same-cycle write bypass
    always_comb begin
        opnd_a = wr_hit[rd_addr_a] ? wr_data : regs_q[rd_addr_a];
        opnd_b = wr_hit[rd_addr_b] ? wr_data : regs_q[rd_addr_b];
        if (R0_ZERO && (rd_addr_a == 4'd0)) begin
            opnd_a = '0;
        end
        if (R0_ZERO && (rd_addr_b == 4'd0)) begin
            opnd_b = '0;
        end
    end

    // Next-state for scoreboard, error flag and read port; a new issue beats a completing write
    always_comb begin
        busy_d      = (busy_q & ~wr_hit) | sb_vec;
        sel_err_d   = sel_err_q || (wr_en && !sel_onehot);
        rd_valid_d  = accept;
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (accept) begin
            rd_data_a_d = opnd_a;
            rd_data_b_d = opnd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            sel_err_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            busy_q      <= busy_d;
            sel_err_q   <= sel_err_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    // Register array storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else if (wr_hit[i]) begin
                regs_q[i] <= wr_data;
            end
        end
    end

    assign busy      = busy_q;
    assign sel_err   = sel_err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_regfile16x32_sb.sv
// Directed bench for regfile16x32_sb; expected operand pairs are queued at request
// time and compared when rd_valid appears.
module tb_regfile16x32_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_sel;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        rd_valid;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        stall;
    logic        sb_set;
    logic [3:0]  sb_addr;
    logic [15:0] busy;
    logic        sel_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic        exp_valid;

    regfile16x32_sb #(.DATA_W(32), .R0_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .stall(stall), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy(busy), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; wr_en = 1'b0; wr_sel = 16'h0; wr_data = 32'h0;
        rd_req = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        sb_set = 1'b0; sb_addr = 4'd0;
        exp_valid = 1'b0;
    endtask

    task automatic read(input logic [3:0] a, input logic [3:0] b);
        rd_req = 1'b1; rd_addr_a = a; rd_addr_b = b;
    endtask

    task automatic expect_read(input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back({a, b});
        exp_valid = 1'b1;
    endtask

    task automatic write(input logic [15:0] sel, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
    endtask

    task automatic check_stall(input logic exp);
        #1;
        chk("stall", 64'(stall), 64'(exp));
    endtask

    // Clock edge, then check rd_valid and pop/compare any delivered operands
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rd_data_a", 64'(rd_data_a), 64'(e[63:32]));
                chk("rd_data_b", 64'(rd_data_b), 64'(e[31:0]));
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("reset_busy", 64'(busy), 64'(16'h0));
        chk("reset_sel_err", 64'(sel_err), 64'(0));
        chk("reset_rd_data_a", 64'(rd_data_a), 64'(0));
        chk("reset_rd_data_b", 64'(rd_data_b), 64'(0));

        // Basic write then read; r0 reads zero
        write(16'h0020, 32'hDEADBEEF);
        tick();
        read(4'd5, 4'd0); expect_read(32'hDEADBEEF, 32'h0); check_stall(1'b0);
        tick();

        // Same-cycle bypass
        write(16'h0080, 32'h1234);
        read(4'd7, 4'd5); expect_read(32'h1234, 32'hDEADBEEF);
        tick();

        // r0 write dropped, even on bypass path
        write(16'h0001, 32'hFFFF);
        read(4'd0, 4'd0); expect_read(32'h0, 32'h0);
        tick();
        read(4'd0, 4'd7); expect_read(32'h0, 32'h1234);
        tick();
        chk("r0_write_no_err", 64'(sel_err), 64'(0));
        chk("r0_never_busy_idle", 64'(busy), 64'(16'h0));

        // Scoreboard stall on r3, held outputs
        sb_set = 1'b1; sb_addr = 4'd3;
        tick();
        chk("busy_r3", 64'(busy), 64'(16'h0008));
        for (int i = 0; i < 3; i++) begin
            read(4'd3, 4'd3); check_stall(1'b1);
            tick();
            chk("hold_a", 64'(rd_data_a), 64'(0));
            chk("hold_b", 64'(rd_data_b), 64'(32'h1234));
        end
        read(4'd7, 4'd3); check_stall(1'b1);
        tick();
        write(16'h0008, 32'h55);
        read(4'd3, 4'd7); expect_read(32'h55, 32'h1234); check_stall(1'b0);
        tick();
        chk("busy_r3_cleared", 64'(busy), 64'(16'h0));

        // Set in the same cycle as a read of that register does not stall
        sb_set = 1'b1; sb_addr = 4'd4;
        read(4'd4, 4'd4); expect_read(32'h0, 32'h0); check_stall(1'b0);
        tick();
        chk("busy_r4", 64'(busy), 64'(16'h0010));
        write(16'h0010, 32'h44);
        tick();
        chk("busy_r4_cleared", 64'(busy), 64'(16'h0));

        // sb_set on r0 is ignored
        sb_set = 1'b1; sb_addr = 4'd0;
        tick();
        chk("busy_r0_ignored", 64'(busy), 64'(16'h0));

        // Set wins over clear on the same register
        sb_set = 1'b1; sb_addr = 4'd9;
        write(16'h0200, 32'h99);
        tick();
        chk("busy_r9_set_wins", 64'(busy), 64'(16'h0200));
        read(4'd0, 4'd9); check_stall(1'b1);
        tick();
        write(16'h0200, 32'h77);
        read(4'd9, 4'd9); expect_read(32'h77, 32'h77); check_stall(1'b0);
        tick();
        chk("busy_r9_cleared", 64'(busy), 64'(16'h0));

        // Illegal selects: multi-hot then zero
        write(16'h0011, 32'hAAAA);
        tick();
        chk("sel_err_multi", 64'(sel_err), 64'(1));
        chk("busy_after_illegal", 64'(busy), 64'(16'h0));
        write(16'h0000, 32'hBBBB);
        read(4'd4, 4'd0); expect_read(32'h44, 32'h0); check_stall(1'b0);
        tick();
        chk("sel_err_zero", 64'(sel_err), 64'(1));
        read(4'd5, 4'd9); expect_read(32'hDEADBEEF, 32'h77);
        tick();
        chk("sel_err_sticky", 64'(sel_err), 64'(1));

        // Reset beats an accepted read and a scoreboard set
        reset = 1'b1;
        sb_set = 1'b1; sb_addr = 4'd4;
        read(4'd5, 4'd9);
        tick();
        chk("rst_busy", 64'(busy), 64'(16'h0));
        chk("rst_sel_err", 64'(sel_err), 64'(0));
        chk("rst_rd_data_a", 64'(rd_data_a), 64'(0));
        for (int r = 0; r < 16; r += 2) begin
            read(4'(r), 4'(r + 1)); expect_read(32'h0, 32'h0);
            tick();
        end

        // Back-to-back reads after reset
        write(16'h8000, 32'hCAFEF00D);
        tick();
        read(4'd15, 4'd15); expect_read(32'hCAFEF00D, 32'hCAFEF00D);
        tick();
        read(4'd15, 4'd1); expect_read(32'hCAFEF00D, 32'h0);
        tick();
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
